// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step-counter width; never below one bit even when a single step suffices.
  function automatic int unsigned cnt_width(input int unsigned nsteps);
    return (nsteps > 1) ? $clog2(nsteps) : 1;
  endfunction

endpackage

// File: rtl/serial_add_sub_step_adder.sv
// Combinational STEP-bit ripple chain of full-adder cells.
module serial_add_sub_step_adder #(
  parameter int unsigned STEP = 1
) (
  input  logic [STEP-1:0] a,
  input  logic [STEP-1:0] b,
  input  logic            cin,
  output logic [STEP-1:0] s,
  output logic            cout,
  output logic            cmsb
);

  logic carry;

  always_comb begin
    carry = cin;
    cmsb  = cin;
    s     = '0;
    for (int i = 0; i < STEP; i++) begin
      // The final iteration leaves the carry into the top bit here.
      cmsb  = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: STEP bits per clock, LSB first, start/ready/done handshake.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned NSTEPS = WIDTH / STEP;
  localparam int unsigned CNTW   = cnt_width(NSTEPS);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NSTEPS - 1);

  if (WIDTH < 2 || (WIDTH % STEP) != 0) begin : g_bad_params
    $error("serial_add_sub: WIDTH must be >= 2 and divisible by STEP");
  end

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [STEP-1:0]  step_s;
  logic             step_cout;
  logic             step_cmsb;
  logic [WIDTH-1:0] res_shifted;

  serial_add_sub_step_adder #(
    .STEP(STEP)
  ) u_step_adder (
    .a   (opa_q[STEP-1:0]),
    .b   (opb_q[STEP-1:0]),
    .cin (carry_q),
    .s   (step_s),
    .cout(step_cout),
    .cmsb(step_cmsb)
  );

  // New step bits enter at the top; after NSTEPS shifts the LSB step sits at bit 0.
  assign res_shifted = WIDTH'({step_s, res_q} >> STEP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d   = A;
          opb_d   = Sub ? ~B : B;
          carry_d = Sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d   = res_shifted;
        opa_d   = opa_q >> STEP;
        opb_d   = opb_q >> STEP;
        carry_d = step_cout;
        cnt_d   = cnt_q + CNTW'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = res_shifted;
          cout_d  = step_cout;
          ovf_d   = step_cmsb ^ step_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done  = (state_q == ST_DONE);
  assign Sum   = sum_q;
  assign Cout  = cout_q;
  assign Ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and random checks of serial_add_sub with STEP=1 and STEP=4 instances.
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, sub1, start4, sub4;
  logic [7:0] a1, b1, a4, b4;
  logic       ready1, busy1, done1, cout1, ovf1;
  logic       ready4, busy4, done4, cout4, ovf4;
  logic [7:0] sum1, sum4;

  int n_assert = 0;
  int n_fail   = 0;

  serial_add_sub #(.WIDTH(8), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Sub(sub1),
    .ready(ready1), .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1), .Ovf(ovf1)
  );

  serial_add_sub #(.WIDTH(8), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Sub(sub4),
    .ready(ready4), .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4), .Ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum[7:0]} for an 8-bit add or subtract.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [7:0] bb;
    logic [8:0] t;
    logic       ov;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
    ov = (a[7] == bb[7]) && (t[7] != a[7]);
    return {ov, t[8], t[7:0]};
  endfunction

  task automatic run_op(input bit s4, input logic [7:0] a, input logic [7:0] b, input logic sub,
                        output int lat);
    @(negedge clk);
    if (s4) begin
      a4 = a; b4 = b; sub4 = sub; start4 = 1'b1;
    end else begin
      a1 = a; b1 = b; sub1 = sub; start1 = 1'b1;
    end
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    lat = 0;
    while (!(s4 ? done4 : done1) && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input bit s4, input logic [7:0] a,
                          input logic [7:0] b, input logic sub, input logic [7:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
    int lat;
    run_op(s4, a, b, sub, lat);
    chk($sformatf("%s.lat", tag), 32'(lat), s4 ? 32'd2 : 32'd8);
    chk($sformatf("%s.sum", tag), 32'(s4 ? sum4 : sum1), 32'(exp_sum));
    chk($sformatf("%s.cout", tag), 32'(s4 ? cout4 : cout1), 32'(exp_cout));
    chk($sformatf("%s.ovf", tag), 32'(s4 ? ovf4 : ovf1), 32'(exp_ovf));
    chk($sformatf("%s.busy", tag), 32'(s4 ? busy4 : busy1), 32'd1);
    @(negedge clk);
    chk($sformatf("%s.ready", tag), 32'(s4 ? ready4 : ready1), 32'd1);
    chk($sformatf("%s.done_off", tag), 32'(s4 ? done4 : done1), 32'd0);
  endtask

  initial begin
    int         lat;
    int         ndone;
    logic [7:0] ra, rb;
    logic       rs;
    logic [9:0] m;

    rst = 1'b1;
    start1 = 1'b0; start4 = 1'b0;
    a1 = '0; b1 = '0; sub1 = 1'b0;
    a4 = '0; b4 = '0; sub4 = 1'b0;
    #12;
    chk("rst.ready", 32'(ready1), 32'd1);
    chk("rst.busy", 32'(busy1), 32'd0);
    chk("rst.done", 32'(done1), 32'd0);
    chk("rst.sum", 32'(sum1), 32'd0);
    chk("rst.cout", 32'(cout1), 32'd0);
    chk("rst.ovf", 32'(ovf1), 32'd0);
    chk("rst.ready4", 32'(ready4), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    check_op("add100_27", 1'b0, 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);
    check_op("add127_1", 1'b0, 8'd127, 8'd1, 1'b0, 8'h80, 1'b0, 1'b1);
    check_op("add255_1", 1'b0, 8'd255, 8'd1, 1'b0, 8'h00, 1'b1, 1'b0);
    check_op("sub5_7", 1'b0, 8'd5, 8'd7, 1'b1, 8'hFE, 1'b0, 1'b0);
    check_op("sub80_1", 1'b0, 8'h80, 8'd1, 1'b1, 8'h7F, 1'b1, 1'b1);

    // start while busy must be ignored; outputs hold during RUN
    @(negedge clk);
    a1 = 8'd3; b1 = 8'd4; sub1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a1 = 8'd9; b1 = 8'd9; start1 = 1'b1;
    @(negedge clk);
    chk("ign.busy", 32'(busy1), 32'd1);
    chk("ign.hold_run", 32'(sum1), 32'h7F);
    start1 = 1'b0; a1 = '0; b1 = '0;
    lat = 3;
    while (!done1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("ign.lat", 32'(lat), 32'd8);
    chk("ign.sum", 32'(sum1), 32'd7);
    @(negedge clk);
    chk("ign.ready", 32'(ready1), 32'd1);
    repeat (3) @(negedge clk);
    chk("ign.hold_idle", 32'(sum1), 32'd7);
    chk("ign.no_requeue", 32'(busy1), 32'd0);

    // reset in the middle of an operation
    @(negedge clk);
    a1 = 8'd1; b1 = 8'd2; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst.sum", 32'(sum1), 32'd0);
    chk("mid_rst.ready", 32'(ready1), 32'd1);
    chk("mid_rst.busy", 32'(busy1), 32'd0);
    chk("mid_rst.done", 32'(done1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    chk("mid_rst.no_done", 32'(ndone), 32'd0);
    check_op("add10_20", 1'b0, 8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0);

    check_op("s4_add200_100", 1'b1, 8'd200, 8'd100, 1'b0, 8'h2C, 1'b1, 1'b0);
    check_op("s4_sub80_1", 1'b1, 8'h80, 8'd1, 1'b1, 8'h7F, 1'b1, 1'b1);

    for (int i = 0; i < 24; i++) begin
      for (int s = 0; s < 2; s++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rs = 1'($urandom_range(0, 1));
        m  = model(ra, rb, rs);
        check_op($sformatf("rnd%0d_s%0d", i, s), s[0], ra, rb, rs, m[7:0], m[8], m[9]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
